// File: rtl/gain_ramp_controller_if.sv
// Settings bus write channel used by gain_ramp_controller.
// The bus driver takes the master modport and the controller takes the slave modport.
interface gain_ramp_controller_if;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;

  modport master (output serial_addr, output serial_data, output serial_strobe);
  modport slave  (input  serial_addr, input  serial_data, input  serial_strobe);
endinterface

// File: rtl/gain_ramp_controller.sv
// Stages gain targets from the settings bus and slews gain1/gain2 toward them once per ramp tick.
// Define GAIN_LIMIT_EN to clamp committed targets to [-GAIN_LIMIT, GAIN_LIMIT].
module gain_ramp_controller #(
  parameter logic [6:0]         BASE       = 7'd64,
  parameter int                 TICK_DIV   = 64,
  parameter logic signed [20:0] GAIN_LIMIT = 21'sd1048575
) (
  input  logic                  clk64,
  input  logic                  reset_n,
  gain_ramp_controller_if.slave bus,
  output logic signed [20:0]    gain1,
  output logic signed [20:0]    gain2,
  output logic                  busy
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  state_t             state_q, state_d;
  logic signed [20:0] shadow1_q, shadow1_d;
  logic signed [20:0] shadow2_q, shadow2_d;
  logic        [19:0] step_q, step_d;
  logic signed [20:0] target1_q, target1_d;
  logic signed [20:0] target2_q, target2_d;
  logic signed [20:0] gain1_q, gain1_d;
  logic signed [20:0] gain2_q, gain2_d;
  logic        [15:0] tick_cnt_q, tick_cnt_d;

  logic               wr_t1, wr_t2, wr_step, commit;
  logic signed [20:0] commit_t1, commit_t2;
  logic               unused_data;

  function automatic logic signed [20:0] clamp_gain(input logic signed [20:0] v);
    if (v > GAIN_LIMIT)  return GAIN_LIMIT;
    if (v < -GAIN_LIMIT) return -GAIN_LIMIT;
    return v;
  endfunction

  // The difference is taken at 22 bits so full-scale swings cannot wrap.
  function automatic logic signed [20:0] ramp_step(input logic signed [20:0] g,
                                                   input logic signed [20:0] t,
                                                   input logic        [19:0] s);
    logic signed [21:0] d;
    logic        [21:0] mag;
    d   = {t[20], t} - {g[20], g};
    mag = d[21] ? 22'(-d) : 22'(d);
    if (s == 20'd0 || mag <= {2'b00, s}) return t;
    if (!d[21])                          return g + $signed({1'b0, s});
    return g - $signed({1'b0, s});
  endfunction

  assign wr_t1   = bus.serial_strobe && (bus.serial_addr == BASE);
  assign wr_t2   = bus.serial_strobe && (bus.serial_addr == BASE + 7'd1);
  assign wr_step = bus.serial_strobe && (bus.serial_addr == BASE + 7'd2);
  assign commit  = bus.serial_strobe && (bus.serial_addr == BASE + 7'd3) && bus.serial_data[0];

  assign unused_data = ^bus.serial_data[31:21];

`ifdef GAIN_LIMIT_EN
  assign commit_t1 = clamp_gain(shadow1_q);
  assign commit_t2 = clamp_gain(shadow2_q);
`else
  assign commit_t1 = shadow1_q;
  assign commit_t2 = shadow2_q;
`endif

  // A commit always wins over a tick in the same cycle so the counter restarts cleanly.
  always_comb begin
    state_d    = state_q;
    shadow1_d  = shadow1_q;
    shadow2_d  = shadow2_q;
    step_d     = step_q;
    target1_d  = target1_q;
    target2_d  = target2_q;
    gain1_d    = gain1_q;
    gain2_d    = gain2_q;
    tick_cnt_d = tick_cnt_q;

    if (wr_t1)   shadow1_d = bus.serial_data[20:0];
    if (wr_t2)   shadow2_d = bus.serial_data[20:0];
    if (wr_step) step_d    = bus.serial_data[19:0];

    if (commit) begin
      target1_d  = commit_t1;
      target2_d  = commit_t2;
      tick_cnt_d = '0;
      state_d    = (commit_t1 != gain1_q || commit_t2 != gain2_q) ? RAMP : IDLE;
    end else if (state_q == RAMP) begin
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_d = '0;
        gain1_d    = ramp_step(gain1_q, target1_q, step_q);
        gain2_d    = ramp_step(gain2_q, target2_q, step_q);
        if (gain1_d == target1_q && gain2_d == target2_q) state_d = IDLE;
      end else begin
        tick_cnt_d = tick_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk64 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shadow1_q  <= '0;
      shadow2_q  <= '0;
      step_q     <= '0;
      target1_q  <= '0;
      target2_q  <= '0;
      gain1_q    <= '0;
      gain2_q    <= '0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shadow1_q  <= shadow1_d;
      shadow2_q  <= shadow2_d;
      step_q     <= step_d;
      target1_q  <= target1_d;
      target2_q  <= target2_d;
      gain1_q    <= gain1_d;
      gain2_q    <= gain2_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign gain1 = gain1_q;
  assign gain2 = gain2_q;
  assign busy  = (state_q == RAMP);

endmodule
